// File: rtl/axis_fifo_rd_bridge.sv
// FIFO read-port to AXI-Stream master bridge.
// A small circular skid buffer hides the FIFO read latency.
module axis_fifo_rd_bridge #(
  parameter int FIFO_WIDTH = 32,
  parameter int RD_LATENCY = 0,
  parameter int PKT_LEN    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [1:0]            buf_level
);

  localparam int         BUF_DEPTH = 2 + RD_LATENCY;
  localparam logic [1:0] LAST_PTR  = 2'(BUF_DEPTH - 1);
  localparam logic [2:0] DEPTH_W   = 3'(BUF_DEPTH);
  localparam bit         HAS_LAST  = (PKT_LEN > 0);
  localparam logic [15:0] LAST_BEAT =
    (PKT_LEN > 0) ? 16'(PKT_LEN - 1) : 16'd0;

  logic [FIFO_WIDTH-1:0] mem_q [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        inflight_q, inflight_d;
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic        rd_en, push, pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
  endfunction

  // Issue depends only on registered occupancy, never on tready.
  always_comb begin
    rd_en = !rst && !fifo_empty &&
            (({1'b0, count_q} + {2'b00, inflight_q}) < DEPTH_W);
    push  = (RD_LATENCY == 0) ? rd_en : inflight_q;
    pop   = (count_q != 2'd0) && m_axis_tready;
    inflight_d = (RD_LATENCY != 0) && rd_en;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
    beat_cnt_d = beat_cnt_q;
    if (HAS_LAST && pop) begin
      beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? 16'd0
                                             : beat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      beat_cnt_q <= 16'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= fifo_rd_data;
    end
  end

  assign fifo_rd_en    = rd_en;
  assign m_axis_tvalid = (count_q != 2'd0);
  assign m_axis_tdata  = mem_q[rd_ptr_q];
  assign m_axis_tlast  = HAS_LAST && (count_q != 2'd0) &&
                         (beat_cnt_q == LAST_BEAT);
  assign buf_level     = count_q;

endmodule

// File: tb/tb_axis_fifo_rd_bridge.sv
// Bench for axis_fifo_rd_bridge: four instances covering both
// read latencies and several packet lengths, fed from FIFO models.
module tb_axis_fifo_rd_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        tready = 1'b0;
  logic        f_empty [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
  logic [31:0] f_data [4] = '{32'd0, 32'd0, 32'd0, 32'd0};
  logic        rd_en [4];
  logic        tvalid [4];
  logic        tlast [4];
  logic [31:0] tdata [4];
  logic [1:0]  lvl [4];

  logic [31:0] fq [4][$];
  logic [31:0] exq [4][$];
  int          beats [4] = '{0, 0, 0, 0};
  int          tlast_cnt [4] = '{0, 0, 0, 0};
  logic        inf_m [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic        hold [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] hold_d [4];
  logic        hold_l [4];
  int          checks = 0;
  int          errors = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    axis_fifo_rd_bridge #(
      .FIFO_WIDTH(32),
      .RD_LATENCY((g == 1 || g == 2) ? 1 : 0),
      .PKT_LEN(g == 2 ? 4 : (g == 3 ? 1 : 0))
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_empty   (f_empty[g]),
      .fifo_rd_data (f_data[g]),
      .fifo_rd_en   (rd_en[g]),
      .m_axis_tdata (tdata[g]),
      .m_axis_tvalid(tvalid[g]),
      .m_axis_tready(tready),
      .m_axis_tlast (tlast[g]),
      .buf_level    (lvl[g])
    );
  end

  function automatic int rl(input int i);
    return (i == 1 || i == 2) ? 1 : 0;
  endfunction

  function automatic int pk(input int i);
    return (i == 2) ? 4 : ((i == 3) ? 1 : 0);
  endfunction

  function automatic void refresh();
    for (int i = 0; i < 4; i++) begin
      f_empty[i] = (fq[i].size() == 0);
      if (rl(i) == 0) f_data[i] = (fq[i].size() != 0) ? fq[i][0] : 32'd0;
    end
  endfunction

  // FIFO read ports: pop on rd_en, latency 0 or 1 per instance.
  always @(posedge clk) begin : fifo_model
    logic        snap [4];
    logic [31:0] w;
    for (int i = 0; i < 4; i++) snap[i] = rd_en[i];
    #1;
    for (int i = 0; i < 4; i++) begin
      inf_m[i] = (rl(i) != 0) && snap[i];
      if (snap[i]) begin
        checks++;
        if (fq[i].size() == 0) begin
          errors++;
          $display("FAIL underflow inst%0d: rd_en=1 while FIFO empty", i);
        end else begin
          w = fq[i].pop_front();
          if (rl(i) != 0) f_data[i] = w;
        end
      end
    end
    refresh();
  end

  // Stream scoreboard, AXIS stability and read-issue occupancy checks.
  always @(negedge clk) begin : monitor
    logic [31:0] ew;
    logic        el;
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        hold[i] = 1'b0;
      end else begin
        if (hold[i]) begin
          checks++;
          if (tvalid[i] !== 1'b1 || tdata[i] !== hold_d[i] ||
              tlast[i] !== hold_l[i]) begin
            errors++;
            $display("FAIL stable inst%0d: v=%b d=%h l=%b want v=1 d=%h l=%b",
                     i, tvalid[i], tdata[i], tlast[i], hold_d[i], hold_l[i]);
          end
        end
        if (tvalid[i] === 1'b1 && tready) begin
          checks++;
          if (exq[i].size() == 0) begin
            errors++;
            $display("FAIL extra_beat inst%0d: got %h, none expected",
                     i, tdata[i]);
          end else begin
            ew = exq[i].pop_front();
            el = (pk(i) > 0) && ((beats[i] % pk(i)) == pk(i) - 1);
            if (tdata[i] !== ew || tlast[i] !== el) begin
              errors++;
              $display("FAIL beat inst%0d #%0d: d=%h l=%b want d=%h l=%b",
                       i, beats[i], tdata[i], tlast[i], ew, el);
            end
            beats[i]++;
            if (tlast[i] === 1'b1) tlast_cnt[i]++;
          end
        end
        if (rd_en[i] === 1'b1) begin
          checks++;
          if (int'(lvl[i]) + int'(inf_m[i]) >= 2 + rl(i)) begin
            errors++;
            $display("FAIL rd_en_full inst%0d: level=%0d inflight=%b",
                     i, lvl[i], inf_m[i]);
          end
        end
        hold[i]   = (tvalid[i] === 1'b1) && !tready;
        hold_d[i] = tdata[i];
        hold_l[i] = tlast[i];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      fq[i].push_back(w);
      exq[i].push_back(w);
    end
    refresh();
  endtask

  task automatic sync_after_reset();
    for (int i = 0; i < 4; i++) begin
      exq[i] = fq[i];
      beats[i] = 0;
      hold[i] = 1'b0;
    end
  endtask

  task automatic drain(input bit rnd);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      done = 1'b1;
      for (int i = 0; i < 4; i++)
        if (exq[i].size() != 0 || fq[i].size() != 0) done = 1'b0;
      if (done) break;
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: left=%0d want 0", exq[0].size());
    end
    tready = 1'b1;
    tick();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tvalid[i] !== 1'b0 || lvl[i] !== 2'd0) begin
        errors++;
        $display("FAIL idle inst%0d: v=%b lvl=%0d want v=0 lvl=0",
                 i, tvalid[i], lvl[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tvalid[i] !== 1'b0 || tlast[i] !== 1'b0 ||
          lvl[i] !== 2'd0 || rd_en[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset inst%0d: v=%b l=%b lvl=%0d rd=%b want 0",
                 i, tvalid[i], tlast[i], lvl[i], rd_en[i]);
      end
    end
    tick();
    rst = 1'b0;
    sync_after_reset();
  endtask

  task automatic test_stream_latency();
    int frd [4];
    int fv [4];
    int lv [4];
    int nv [4];
    for (int i = 0; i < 4; i++) begin
      frd[i] = -1; fv[i] = -1; lv[i] = -1; nv[i] = 0;
    end
    tready = 1'b1;
    for (int w = 1; w <= 8; w++) load(32'(w));
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (rd_en[i] === 1'b1 && frd[i] < 0) frd[i] = k;
        if (tvalid[i] === 1'b1) begin
          if (fv[i] < 0) fv[i] = k;
          lv[i] = k;
          nv[i]++;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (frd[i] != 0 || fv[i] - frd[i] != 1 + rl(i)) begin
        errors++;
        $display("FAIL latency inst%0d: rd@%0d valid@%0d want gap %0d",
                 i, frd[i], fv[i], 1 + rl(i));
      end
      checks++;
      if (nv[i] != 8 || lv[i] - fv[i] != 7) begin
        errors++;
        $display("FAIL contiguous inst%0d: beats=%0d span=%0d want 8/7",
                 i, nv[i], lv[i] - fv[i]);
      end
    end
    drain(1'b0);
  endtask

  task automatic test_backpressure();
    tready = 1'b0;
    for (int w = 1; w <= 8; w++) load(32'(w));
    repeat (10) tick();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (int'(lvl[i]) != 2 + rl(i) || rd_en[i] !== 1'b0 ||
          tvalid[i] !== 1'b1 || tdata[i] !== 32'h1) begin
        errors++;
        $display("FAIL backpressure inst%0d: lvl=%0d rd=%b v=%b d=%h want lvl=%0d rd=0 v=1 d=1",
                 i, lvl[i], rd_en[i], tvalid[i], tdata[i], 2 + rl(i));
      end
    end
    drain(1'b0);
  endtask

  task automatic test_random();
    int n;
    n = 0;
    while (n < 200) begin
      tick();
      tready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        load($urandom);
        n++;
      end
    end
    drain(1'b1);
  endtask

  task automatic test_packets();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sync_after_reset();
    for (int i = 0; i < 4; i++) tlast_cnt[i] = 0;
    tready = 1'b1;
    for (int w = 1; w <= 12; w++) load(32'h100 + 32'(w));
    drain(1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tlast_cnt[i] != (pk(i) == 0 ? 0 : 12 / pk(i))) begin
        errors++;
        $display("FAIL tlast_count inst%0d: got %0d want %0d", i,
                 tlast_cnt[i], pk(i) == 0 ? 0 : 12 / pk(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    tready = 1'b1;
    load(32'hA1);
    load(32'hA2);
    drain(1'b0);
    tready = 1'b0;
    for (int w = 0; w < 8; w++) load(32'h200 + 32'(w));
    repeat (3) tick();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lvl[i] !== 2'd2 || inf_m[i] !== 1'(rl(i))) begin
        errors++;
        $display("FAIL pre_reset inst%0d: lvl=%0d inflight=%b want 2/%0d",
                 i, lvl[i], inf_m[i], rl(i));
      end
    end
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tvalid[i] !== 1'b0 || lvl[i] !== 2'd0 || rd_en[i] !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset inst%0d: v=%b lvl=%0d rd=%b want 0",
                 i, tvalid[i], lvl[i], rd_en[i]);
      end
    end
    rst = 1'b0;
    sync_after_reset();
    tready = 1'b1;
    drain(1'b0);
  endtask

  initial begin
    refresh();
    test_reset();
    test_stream_latency();
    test_backpressure();
    test_random();
    test_packets();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_fifo_rd_bridge.md
Name: axis_fifo_rd_bridge

Overview:
- Downstream stage of the AXIS data FIFO, in the read clock domain.
- Drains the FIFO read port (rd_en/empty/rd_data) and presents the words as an AXI-Stream master (tvalid/tready/tdata/tlast).
- Absorbs FIFO read latency with a small internal buffer, so the stream runs at one beat per clock under sustained tready without a combinational path from tready to fifo_rd_en.
- Optionally frames the stream into fixed-length packets via tlast.

Parameters:
- FIFO_WIDTH, 32, data width in bits; matches the FIFO.
- RD_LATENCY, 0, FIFO read latency in cycles. Legal values:
  - 0: rd_data shows the head word whenever empty=0 (first-word fall-through).
  - 1: rd_data is valid the cycle after rd_en.
- PKT_LEN, 0, beats per packet for tlast generation. 0 means tlast is held 0. Legal range 0 to 65535.

Ports:
- clk  in  1  read-domain clock (the FIFO rd_clk).
- rst  in  1  synchronous active-high reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_data  in  FIFO_WIDTH  FIFO read data.
- fifo_rd_en  out  1  FIFO read strobe.
- m_axis_tdata  out  FIFO_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready from the sink.
- m_axis_tlast  out  1  last beat of a packet.
- buf_level  out  2  number of words held in the internal buffer, 0 to BUF_DEPTH.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high.
- Buffer: circular, BUF_DEPTH = 2 + RD_LATENCY entries, with registered wr_ptr, rd_ptr, count, and in-flight flag `inflight` (only used when RD_LATENCY=1).
- Reset (rst=1 at a clk edge):
  - count, pointers, inflight and beat_cnt clear to 0.
  - m_axis_tvalid=0, m_axis_tlast=0, buf_level=0.
  - fifo_rd_en is forced 0 combinationally while rst=1.
- Read issue: fifo_rd_en = !rst && !fifo_empty && (count + inflight < BUF_DEPTH).
  - Uses registered state only; never depends on m_axis_tready.
- Capture, RD_LATENCY=0: fifo_rd_data is written into buffer[wr_ptr] at the same edge where fifo_rd_en=1.
- Capture, RD_LATENCY=1:
  - inflight <= fifo_rd_en.
  - When inflight=1, fifo_rd_data is written into buffer[wr_ptr] at that edge.
- Output:
  - m_axis_tvalid = (count != 0).
  - m_axis_tdata = buffer[rd_ptr], driven from storage registers.
  - A beat transfers on an edge with tvalid && tready.
- Count update: count_next = count + push - pop. Simultaneous push and pop leave count unchanged. Pointers wrap modulo BUF_DEPTH.
- AXIS rule: while tvalid=1 and tready=0, tdata and tlast hold stable. A push never alters the head entry.
- Throughput: sustained tready=1 and non-empty FIFO give one beat per clk after the initial fill.
  - First beat appears 1 cycle after the first rd_en for RD_LATENCY=0.
  - First beat appears 2 cycles after the first rd_en for RD_LATENCY=1.
- Backpressure: with tready=0, the buffer fills to BUF_DEPTH, then fifo_rd_en drops to 0. No FIFO word is lost or duplicated.
- FIFO empties mid-stream: tvalid falls when count reaches 0. Bubbles are permitted; data order is preserved.
- tlast (PKT_LEN>0):
  - beat_cnt is 16 bits and increments on each transfer.
  - m_axis_tlast = tvalid && (beat_cnt == PKT_LEN-1).
  - On the transfer with tlast=1, beat_cnt wraps to 0.
  - PKT_LEN=1 gives tlast on every beat.
- tlast (PKT_LEN=0): tlast is constant 0 and beat_cnt stays 0.
- buf_level = count, registered.
- Reset mid-operation: buffered words and any in-flight read are discarded (known data loss, consistent with the FIFO reset domains). The first post-reset beat is packet beat 0.

Test Plan:
- RD_LATENCY=0, PKT_LEN=0: preload FIFO with 0x00000001..0x00000008, hold tready=1 -> 8 consecutive beats, data 1..8 in order, tvalid high 8 contiguous cycles, tlast always 0.
- RD_LATENCY=1: same 8 words, tready=1 -> first beat 2 cycles after the first rd_en, then 8 back-to-back beats; rd_en never asserts while count+inflight=3.
- Backpressure: 8 words in FIFO, tready=0 for 10 cycles -> buf_level saturates at BUF_DEPTH (2 or 3), rd_en=0 afterwards, tdata frozen at 0x00000001; release tready -> words 1..8, none lost or duplicated.
- Random tready (50%), 200 random words, both latencies -> scoreboard matches exact order; tdata/tlast stable whenever tvalid && !tready.
- PKT_LEN=4, 12 words -> tlast high on beats 4, 8 and 12 only; PKT_LEN=1 -> tlast on every beat.
- Assert rst for 1 cycle with buf_level=2 and one read in flight -> next cycle tvalid=0 and buf_level=0; subsequent words stream correctly and beat_cnt restarts at 0.
